// File: rtl/wb_scoreboard.sv
// wb_scoreboard: writeback merge of ALU and long-latency results with busy scoreboard
// Ports: clk, rst (async, active-low); iss_valid/iss_rd mark a register busy;
//        chk_rs1/rs2/rd -> hazard; alu_* single-cycle results; lr_* long returns
//        (valid/ready) buffered in a FIFO; WE3/AD3/WD3 registered regfile write;
//        stall_req when FIFO full; busy bitmap; err sticky on return to a non-busy rd.
module wb_scoreboard #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      chk_rs1,
    input  logic [4:0]      chk_rs2,
    input  logic [4:0]      chk_rd,
    output logic            hazard,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lr_valid,
    output logic            lr_ready,
    input  logic [4:0]      lr_rd,
    input  logic [XLEN-1:0] lr_data,
    output logic            WE3,
    output logic [4:0]      AD3,
    output logic [XLEN-1:0] WD3,
    output logic            stall_req,
    output logic [31:0]     busy,
    output logic            err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     busy_q, busy_d;
    logic            we3_q, wb_long_q, err_q;
    logic [4:0]      ad3_q, sel_rd;
    logic [XLEN-1:0] wd3_q, sel_data;
    logic            push, pop;

    // Ready depends only on occupancy so there is no combinational path from pop.
    assign lr_ready  = cnt_q < CW'(FIFO_DEPTH);
    assign stall_req = cnt_q == CW'(FIFO_DEPTH);
    assign push      = lr_valid & lr_ready;
    // ALU always wins; the FIFO only drains in ALU bubbles.
    assign pop       = ~alu_valid & (cnt_q != '0);
    assign sel_rd    = alu_valid ? alu_rd : fifo_rd_q[rd_ptr_q];
    assign sel_data  = alu_valid ? alu_data : fifo_data_q[rd_ptr_q];
    assign cnt_d     = cnt_q + CW'(push) - CW'(pop);
    assign hazard    = (busy_q[chk_rs1] & |chk_rs1) | (busy_q[chk_rs2] & |chk_rs2) |
                       (busy_q[chk_rd] & |chk_rd);
    assign WE3       = we3_q;
    assign AD3       = ad3_q;
    assign WD3       = wd3_q;
    assign busy      = busy_q;
    assign err       = err_q;

    // Clear on the commit edge of a long write; a same-cycle issue re-sets it.
    always_comb begin
        busy_d = busy_q;
        if (we3_q && wb_long_q) busy_d[ad3_q] = 1'b0;
        if (iss_valid && iss_rd != '0) busy_d[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q    <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            we3_q     <= 1'b0;
            wb_long_q <= 1'b0;
            ad3_q     <= '0;
            wd3_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            we3_q     <= (alu_valid | pop) & (sel_rd != '0);
            wb_long_q <= pop;
            if (alu_valid | pop) begin
                ad3_q <= sel_rd;
                wd3_q <= sel_data;
            end
            err_q     <= err_q | (push & ~(busy_q[lr_rd] & |lr_rd));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_q[wr_ptr_q]   <= lr_rd;
            fifo_data_q[wr_ptr_q] <= lr_data;
        end
    end
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: self-checking bench for wb_scoreboard
module tb_wb_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd, chk_rs1, chk_rs2, chk_rd;
    logic        hazard;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lr_valid, lr_ready;
    logic [4:0]  lr_rd;
    logic [31:0] lr_data;
    logic        WE3;
    logic [4:0]  AD3;
    logic [31:0] WD3;
    logic        stall_req;
    logic [31:0] busy;
    logic        err;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic        av;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        we;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tbl[6];
    int   n_chk = 0;
    int   n_fail = 0;

    wb_scoreboard #(.XLEN(32), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd), .hazard(hazard),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lr_valid(lr_valid), .lr_ready(lr_ready), .lr_rd(lr_rd), .lr_data(lr_data),
        .WE3(WE3), .AD3(AD3), .WD3(WD3),
        .stall_req(stall_req), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance one cycle and score any register-file write against the queue.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (WE3) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got AD3=%0d WD3=%0h expected no write", AD3, WD3);
            end else begin
                e = exp_q.pop_front();
                check("wb_ad3", 64'(AD3), 64'(e.rd));
                check("wb_wd3", 64'(WD3), 64'(e.d));
            end
        end
    endtask

    task automatic issue(input logic [4:0] rd);
        iss_valid = 1'b1;
        iss_rd    = rd;
        tick();
        iss_valid = 1'b0;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        wr_t e;
        e.rd = rd;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    initial begin
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1};
        tbl[1] = '{1'b1, 5'd0,  32'h11111111, 1'b0};
        tbl[2] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1};
        tbl[3] = '{1'b0, 5'd3,  32'h00000033, 1'b0};
        tbl[4] = '{1'b1, 5'd1,  32'h00000001, 1'b1};
        tbl[5] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0};

        rst = 1'b0; iss_valid = 1'b0; iss_rd = '0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lr_valid = 1'b0; lr_rd = '0; lr_data = '0;
        tick();
        tick();
        check("rst_we3", 64'(WE3), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_lr_ready", 64'(lr_ready), 64'd1);
        check("rst_stall", 64'(stall_req), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b1;
        tick();
        check("idle_we3", 64'(WE3), 64'd0);
        check("idle_hazard_x0", 64'(hazard), 64'd0);

        // ALU writes: one-cycle latency, x0 suppressed
        for (int i = 0; i < 6; i++) begin
            alu_valid = tbl[i].av;
            alu_rd    = tbl[i].rd;
            alu_data  = tbl[i].d;
            if (tbl[i].we) expect_wr(tbl[i].rd, tbl[i].d);
            tick();
            check($sformatf("alu_we3_%0d", i), 64'(WE3), 64'(tbl[i].we));
        end
        alu_valid = 1'b0;
        tick();
        check("alu_idle_we3", 64'(WE3), 64'd0);

        // Long op rd=7
        issue(5'd7);
        chk_rs1 = 5'd7; #1;
        check("haz_rs1_7", 64'(hazard), 64'd1);
        check("busy7_set", 64'(busy[7]), 64'd1);
        chk_rs1 = 5'd0; chk_rd = 5'd7; #1;
        check("haz_rd_7", 64'(hazard), 64'd1);
        chk_rd = 5'd0; chk_rs2 = 5'd6; #1;
        check("haz_rs2_6", 64'(hazard), 64'd0);
        chk_rs2 = 5'd0;
        lr_valid = 1'b1; lr_rd = 5'd7; lr_data = 32'h1234;
        check("lr7_ready", 64'(lr_ready), 64'd1);
        expect_wr(5'd7, 32'h1234);
        tick();
        lr_valid = 1'b0;
        check("lr7_n1_we3", 64'(WE3), 64'd0);
        tick();
        check("lr7_n2_we3", 64'(WE3), 64'd1);
        check("busy7_n2", 64'(busy[7]), 64'd1);
        chk_rs1 = 5'd7;
        tick();
        check("busy7_n3", 64'(busy[7]), 64'd0);
        check("haz7_n3", 64'(hazard), 64'd0);
        chk_rs1 = 5'd0;

        // Contention: FIFO holds rd=8 while ALU writes for 3 cycles
        issue(5'd8);
        lr_valid = 1'b1; lr_rd = 5'd8; lr_data = 32'h88;
        alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'hA2;
        expect_wr(5'd2, 32'hA2);
        tick();
        lr_valid = 1'b0;
        alu_rd = 5'd3; alu_data = 32'hA3;
        expect_wr(5'd3, 32'hA3);
        tick();
        alu_rd = 5'd4; alu_data = 32'hA4;
        expect_wr(5'd4, 32'hA4);
        tick();
        check("cont_busy8_held", 64'(busy[8]), 64'd1);
        alu_valid = 1'b0;
        expect_wr(5'd8, 32'h88);
        tick();
        check("cont_we3_8", 64'(WE3), 64'd1);
        tick();
        check("cont_busy8_clr", 64'(busy[8]), 64'd0);

        // Full FIFO, backpressure, simultaneous push/pop
        issue(5'd10);
        issue(5'd11);
        issue(5'd15);
        alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hD13;
        lr_valid = 1'b1; lr_rd = 5'd10; lr_data = 32'h10A;
        expect_wr(5'd13, 32'hD13);
        tick();
        alu_rd = 5'd14; alu_data = 32'hD14;
        lr_rd = 5'd11; lr_data = 32'h11B;
        expect_wr(5'd14, 32'hD14);
        tick();
        check("full_lr_ready", 64'(lr_ready), 64'd0);
        check("full_stall", 64'(stall_req), 64'd1);
        alu_valid = 1'b0;
        lr_rd = 5'd15; lr_data = 32'h15F;
        expect_wr(5'd10, 32'h10A);
        tick();
        check("drain_lr_ready", 64'(lr_ready), 64'd1);
        check("drain_stall", 64'(stall_req), 64'd0);
        expect_wr(5'd11, 32'h11B);
        tick();
        lr_valid = 1'b0;
        check("pushpop_lr_ready", 64'(lr_ready), 64'd1);
        expect_wr(5'd15, 32'h15F);
        tick();
        tick();
        check("drain_idle_we3", 64'(WE3), 64'd0);
        check("drain_err", 64'(err), 64'd0);

        // Set/clear collision on rd=9
        issue(5'd9);
        lr_valid = 1'b1; lr_rd = 5'd9; lr_data = 32'h99;
        expect_wr(5'd9, 32'h99);
        tick();
        lr_valid = 1'b0;
        tick();
        check("coll_we3", 64'(WE3), 64'd1);
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        check("coll_busy9", 64'(busy[9]), 64'd1);
        tick();
        check("coll_busy9_hold", 64'(busy[9]), 64'd1);

        // Spurious return to non-busy rd=12
        check("spur_err_pre", 64'(err), 64'd0);
        lr_valid = 1'b1; lr_rd = 5'd12; lr_data = 32'hC0C0;
        expect_wr(5'd12, 32'hC0C0);
        tick();
        lr_valid = 1'b0;
        check("spur_err_set", 64'(err), 64'd1);
        tick();
        tick();
        check("spur_err_sticky", 64'(err), 64'd1);

        // Asynchronous reset with two FIFO entries pending
        issue(5'd20);
        issue(5'd21);
        alu_valid = 1'b1; alu_rd = 5'd22; alu_data = 32'h22;
        lr_valid = 1'b1; lr_rd = 5'd20; lr_data = 32'h20;
        expect_wr(5'd22, 32'h22);
        tick();
        alu_rd = 5'd23; alu_data = 32'h23;
        lr_rd = 5'd21; lr_data = 32'h21;
        expect_wr(5'd23, 32'h23);
        tick();
        alu_valid = 1'b0; lr_valid = 1'b0;
        check("mid_stall_pre", 64'(stall_req), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_lr_ready", 64'(lr_ready), 64'd1);
        check("mid_stall", 64'(stall_req), 64'd0);
        check("mid_we3", 64'(WE3), 64'd0);
        check("mid_err", 64'(err), 64'd0);
        #1 rst = 1'b1;
        tick();
        tick();
        tick();
        check("post_rst_we3", 64'(WE3), 64'd0);
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
